unified_memory_arbiter: RTL

- Sits directly downstream of the single-cycle core's fetch and memory ports.
- Merges the instruction-fetch and data-access request streams onto one shared memory port with a req/gnt/rvalid handshake.
- Returns the core-facing valid/ready/data/address-echo signals that the core's hazard logic consumes.
- Data requests have priority, with alternation when both are pending so fetch cannot starve; includes a sticky timeout error.

---
 rtl/unified_memory_arbiter_pkg.sv | 6 +
 rtl/unified_memory_arbiter_if.sv | 47 ++++
 rtl/unified_memory_arbiter_mem_req_buffer.sv | 38 +++
 rtl/unified_memory_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/unified_memory_arbiter_pkg.sv
// unified_memory_arbiter_pkg: shared state/source encodings and timeout counter width
package unified_memory_arbiter_pkg;
  localparam int TO_CNT_W = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  typedef enum logic {SRC_FETCH = 1'b0, SRC_DATA = 1'b1} src_t;
endpackage

// File: rtl/unified_memory_arbiter_if.sv
// unified_memory_arbiter_if: core fetch/data channels plus the shared memory port
// master: arbiter side (consumes core requests and mem responses, drives the rest)
// slave: core + memory side
interface unified_memory_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int NUM_BYTES = DATA_WIDTH / 8
);
  logic core_fetch_read;
  logic [ADDRESS_BITS-1:0] core_fetch_address;
  logic core_fetch_ready;
  logic core_fetch_valid;
  logic [DATA_WIDTH-1:0] core_fetch_data;
  logic [ADDRESS_BITS-1:0] core_fetch_address_back;
  logic core_mem_read;
  logic core_mem_write;
  logic [NUM_BYTES-1:0] core_mem_byte_en;
  logic [ADDRESS_BITS-1:0] core_mem_address;
  logic [DATA_WIDTH-1:0] core_mem_wdata;
  logic core_mem_ready;
  logic core_mem_valid;
  logic [DATA_WIDTH-1:0] core_mem_rdata;
  logic [ADDRESS_BITS-1:0] core_mem_address_back;
  logic mem_req;
  logic mem_we;
  logic [NUM_BYTES-1:0] mem_byte_en;
  logic [ADDRESS_BITS-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic mem_gnt;
  logic mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic timeout_error;
  modport master (
    input core_fetch_read, core_fetch_address, core_mem_read, core_mem_write,
          core_mem_byte_en, core_mem_address, core_mem_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output core_fetch_ready, core_fetch_valid, core_fetch_data, core_fetch_address_back,
           core_mem_ready, core_mem_valid, core_mem_rdata, core_mem_address_back,
           mem_req, mem_we, mem_byte_en, mem_address, mem_wdata, timeout_error
  );
  modport slave (
    output core_fetch_read, core_fetch_address, core_mem_read, core_mem_write,
           core_mem_byte_en, core_mem_address, core_mem_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input core_fetch_ready, core_fetch_valid, core_fetch_data, core_fetch_address_back,
          core_mem_ready, core_mem_valid, core_mem_rdata, core_mem_address_back,
          mem_req, mem_we, mem_byte_en, mem_address, mem_wdata, timeout_error
  );
endinterface

// File: rtl/unified_memory_arbiter_mem_req_buffer.sv
// mem_req_buffer: holds the accepted request while it is presented on the shared port
// Ports: clock, reset (async active-low clear), load, *_in request fields, registered fields out
module mem_req_buffer
  import unified_memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int NUM_BYTES = DATA_WIDTH / 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [ADDRESS_BITS-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]   wdata_in,
  input  logic [NUM_BYTES-1:0]    byte_en_in,
  input  logic                    we_in,
  input  src_t                    src_in,
  output logic [ADDRESS_BITS-1:0] address,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [NUM_BYTES-1:0]    byte_en,
  output logic                    we,
  output src_t                    src
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      address <= '0;
      wdata <= '0;
      byte_en <= '0;
      we <= 1'b0;
      src <= SRC_FETCH;
    end else if (load) begin
      address <= address_in;
      wdata <= wdata_in;
      byte_en <= byte_en_in;
      we <= we_in;
      src <= src_in;
    end
endmodule

// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: merges fetch and data requests onto one shared req/gnt/rvalid port
// Ports: clock, reset (async active-low), scan (debug enable),
//   bus (master modport: core fetch/data channels, shared memory port, sticky timeout_error)
module unified_memory_arbiter
  import unified_memory_arbiter_pkg::*;
#(
  parameter int CORE = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int NUM_BYTES = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input logic clock,
  input logic reset,
  input logic scan,
  unified_memory_arbiter_if.master bus
);
  state_t state, state_nxt;
  src_t last_grant, buf_src;
  logic [TO_CNT_W-1:0] to_cnt;
  logic [ADDRESS_BITS-1:0] buf_address;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [NUM_BYTES-1:0] buf_byte_en;
  logic buf_we, data_req, grant_data, accept, done, timeout, unused_scan;
  assign data_req = bus.core_mem_read | bus.core_mem_write;
  // when both sides request, the side not granted last time wins
  assign grant_data = data_req & (!bus.core_fetch_read | last_grant == SRC_FETCH);
  assign accept = state == IDLE & (data_req | bus.core_fetch_read);
  assign done = bus.mem_rvalid & (state == WAIT | state == ISSUE & bus.mem_gnt);
  // to_cnt holds cycles already spent, so this fires on the TIMEOUT_CYCLES-th busy cycle
  assign timeout = state != IDLE & !done & to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1);
  assign unused_scan = scan & (CORE >= 0) & (SCAN_CYCLES_MIN <= SCAN_CYCLES_MAX);
  mem_req_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDRESS_BITS(ADDRESS_BITS),
    .NUM_BYTES(NUM_BYTES)
  ) u_buf (
    .clock,
    .reset,
    .load(accept),
    .address_in(grant_data ? bus.core_mem_address : bus.core_fetch_address),
    .wdata_in(bus.core_mem_wdata),
    .byte_en_in(grant_data & bus.core_mem_write ? bus.core_mem_byte_en : '1),
    .we_in(grant_data & bus.core_mem_write),
    .src_in(grant_data ? SRC_DATA : SRC_FETCH),
    .address(buf_address),
    .wdata(buf_wdata),
    .byte_en(buf_byte_en),
    .we(buf_we),
    .src(buf_src)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = timeout ? IDLE
      : state == IDLE ? (accept ? ISSUE : IDLE)
      : state == ISSUE ? (done ? IDLE : bus.mem_gnt ? WAIT : ISSUE)
      : state == WAIT ? (done ? IDLE : WAIT) : IDLE;
    bus.mem_req = state == ISSUE;
    bus.mem_we = buf_we;
    bus.mem_byte_en = buf_byte_en;
    bus.mem_address = buf_address;
    bus.mem_wdata = buf_wdata;
    bus.core_mem_ready = reset & state == IDLE;
    bus.core_fetch_ready = reset & state == IDLE & !(data_req & last_grant == SRC_FETCH);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      last_grant <= SRC_FETCH;
      to_cnt <= '0;
      bus.timeout_error <= 1'b0;
      bus.core_fetch_valid <= 1'b0;
      bus.core_mem_valid <= 1'b0;
      bus.core_fetch_data <= '0;
      bus.core_fetch_address_back <= '0;
      bus.core_mem_rdata <= '0;
      bus.core_mem_address_back <= '0;
    end else begin
      if (accept) last_grant <= grant_data ? SRC_DATA : SRC_FETCH;
      to_cnt <= state == IDLE ? '0 : to_cnt + 1'b1;
      if (timeout) bus.timeout_error <= 1'b1;
      bus.core_fetch_valid <= done & buf_src == SRC_FETCH;
      bus.core_mem_valid <= done & buf_src == SRC_DATA;
      if (done & buf_src == SRC_FETCH) begin
        bus.core_fetch_data <= bus.mem_rdata;
        bus.core_fetch_address_back <= buf_address;
      end
      if (done & buf_src == SRC_DATA) begin
        bus.core_mem_address_back <= buf_address;
        if (!buf_we) bus.core_mem_rdata <= bus.mem_rdata;
      end
    end
endmodule
